// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
// Drains fixed-length packets from a show-ahead FIFO onto an AXI-Stream style
// output. A packet starts from IDLE when i_enable is high and i_pkt_len is
// non-zero. Exactly len_q words are then popped and streamed, with tlast on
// the final word. Once the last word has been accepted downstream, a
// one-cycle o_pkt_done pulse is produced.
//
// Ports
//   clk, rst          : clock (rising edge), synchronous active-high reset
//   i_fifo_r_data     : FIFO head word (valid while i_fifo_not_empty)
//   i_fifo_not_empty  : FIFO holds at least one word
//   o_fifo_r_stb      : pop strobe, pops the head word in the same cycle
//   i_enable          : level request to start a packet
//   i_pkt_len         : words per packet, sampled when a packet starts
//   o_axis_tdata      : stream data
//   o_axis_tvalid     : stream data valid
//   i_axis_tready     : downstream accepts the word this cycle
//   o_axis_tlast      : final word of the packet
//   o_busy            : high while a packet is in progress
//   o_pkt_done        : one-cycle pulse after the last word is accepted
module fifo_stream_reader #(
   parameter int WIDTH = 4,
   parameter int LEN_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] i_fifo_r_data,
   input  logic             i_fifo_not_empty,
   output logic             o_fifo_r_stb,
   input  logic             i_enable,
   input  logic [LEN_W-1:0] i_pkt_len,
   output logic [WIDTH-1:0] o_axis_tdata,
   output logic             o_axis_tvalid,
   input  logic             i_axis_tready,
   output logic             o_axis_tlast,
   output logic             o_busy,
   output logic             o_pkt_done
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t state;
   state_t state_next;

   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] pop_cnt;
   logic [LEN_W-1:0] sent_cnt;
   logic             start;
   logic             xfer;

   assign start = (state == IDLE) && i_enable && (i_pkt_len != '0);
   assign xfer  = o_axis_tvalid && i_axis_tready;

   // Pop only while the output register is free or being emptied this cycle.
   // pop_cnt < len_q stops exactly at len_q words, even at the maximum length.
   // The strobe is gated by rst so that no word is lost during a reset cycle.
   assign o_fifo_r_stb = !rst && (state == RUN) && i_fifo_not_empty &&
                         (pop_cnt < len_q) && (!o_axis_tvalid || i_axis_tready);

   assign o_busy = !rst && (state == RUN);

   // Next-state logic: leave RUN once the tlast word has been accepted, and
   // spend one cycle in DONE, which drives the completion pulse.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = RUN;
            end
         end
         RUN: begin
            if (xfer && o_axis_tlast) begin
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State register plus packet bookkeeping and the output register.
   // A pop reloads the output register. A transfer with no pop empties it.
   // With no pop and no transfer, the word is held stable under backpressure.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         len_q         <= '0;
         pop_cnt       <= '0;
         sent_cnt      <= '0;
         o_axis_tdata  <= '0;
         o_axis_tvalid <= 1'b0;
         o_axis_tlast  <= 1'b0;
         o_pkt_done    <= 1'b0;
      end else begin
         state      <= state_next;
         o_pkt_done <= (state_next == DONE);

         if (start) begin
            len_q    <= i_pkt_len;
            pop_cnt  <= '0;
            sent_cnt <= '0;
         end

         if (o_fifo_r_stb) begin
            o_axis_tdata  <= i_fifo_r_data;
            o_axis_tvalid <= 1'b1;
            o_axis_tlast  <= (pop_cnt == (len_q - LEN_W'(1)));
            pop_cnt       <= pop_cnt + LEN_W'(1);
         end else if (xfer) begin
            o_axis_tvalid <= 1'b0;
            o_axis_tlast  <= 1'b0;
         end

         if (xfer) begin
            sent_cnt <= sent_cnt + LEN_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader
// Directed bench for fifo_stream_reader. A small behavioural show-ahead FIFO
// feeds the DUT. Cycle-exact vectors cover single-packet behaviour. The
// multi-cycle corner cases use hand-written sequences: empty-FIFO stall,
// zero length, reset mid-packet, and back-to-back packets.
module tb_fifo_stream_reader;

   logic       clk;
   logic       rst;
   logic [3:0] i_fifo_r_data;
   logic       i_fifo_not_empty;
   logic       o_fifo_r_stb;
   logic       i_enable;
   logic [7:0] i_pkt_len;
   logic [3:0] o_axis_tdata;
   logic       o_axis_tvalid;
   logic       i_axis_tready;
   logic       o_axis_tlast;
   logic       o_busy;
   logic       o_pkt_done;

   int checks   = 0;
   int failures = 0;

   logic [3:0] mem [64];
   int         wrPtr = 0;
   int         rdPtr = 0;

   logic [3:0] rxData [$];
   logic       rxLast [$];
   int         doneCnt = 0;

   typedef struct {
      logic       en;
      logic       rdy;
      logic [7:0] len;
      logic       stb;
      logic       vld;
      logic [3:0] data;
      logic       last;
      logic       busy;
      logic       done;
   } vec_t;

   vec_t vecs [17];

   fifo_stream_reader #(
      .WIDTH(4),
      .LEN_W(8)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .i_fifo_r_data    (i_fifo_r_data),
      .i_fifo_not_empty (i_fifo_not_empty),
      .o_fifo_r_stb     (o_fifo_r_stb),
      .i_enable         (i_enable),
      .i_pkt_len        (i_pkt_len),
      .o_axis_tdata     (o_axis_tdata),
      .o_axis_tvalid    (o_axis_tvalid),
      .i_axis_tready    (i_axis_tready),
      .o_axis_tlast     (o_axis_tlast),
      .o_busy           (o_busy),
      .o_pkt_done       (o_pkt_done)
   );

   // 10-unit clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Show-ahead FIFO model: the head word is always visible, and the strobe
   // pops it at the clock edge.
   assign i_fifo_r_data    = mem[rdPtr[5:0]];
   assign i_fifo_not_empty = (wrPtr != rdPtr);

   always @(posedge clk) begin
      if (o_fifo_r_stb) begin
         rdPtr <= rdPtr + 1;
      end
   end

   // Record every accepted word and every done pulse, away from the edge.
   // Words held while reset is asserted are dropped, not transferred.
   always @(negedge clk) begin
      if (!rst && o_axis_tvalid && i_axis_tready) begin
         rxData.push_back(o_axis_tdata);
         rxLast.push_back(o_axis_tlast);
      end
      if (o_pkt_done) begin
         doneCnt <= doneCnt + 1;
      end
   end

   task automatic pushWord(input logic [3:0] w);
      mem[wrPtr[5:0]] = w;
      wrPtr = wrPtr + 1;
   endtask

   task automatic applyStimulus(input logic en, input logic rdy, input logic [7:0] len);
      @(posedge clk);
      #1;
      i_enable      = en;
      i_axis_tready = rdy;
      i_pkt_len     = len;
   endtask

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   function automatic vec_t mk(input logic en, input logic rdy, input logic [7:0] len,
                               input logic stb, input logic vld, input logic [3:0] data,
                               input logic last, input logic busy, input logic done);
      vec_t v;
      v.en = en; v.rdy = rdy; v.len = len; v.stb = stb; v.vld = vld;
      v.data = data; v.last = last; v.busy = busy; v.done = done;
      return v;
   endfunction

   initial begin
      int base;
      int doneBase;
      int ptrBase;
      int n;
      int gap;
      int nd;
      int doneAt [3];

      // Rows 0-7: words 1..4 with len 4 and tready high. Enable drops after
      // the start cycle, which must have no effect on the packet.
      vecs[0]  = mk(1'b1, 1'b1, 8'd4, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
      vecs[1]  = mk(1'b0, 1'b1, 8'd4, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
      vecs[2]  = mk(1'b0, 1'b1, 8'd4, 1'b1, 1'b1, 4'h1, 1'b0, 1'b1, 1'b0);
      vecs[3]  = mk(1'b0, 1'b1, 8'd4, 1'b1, 1'b1, 4'h2, 1'b0, 1'b1, 1'b0);
      vecs[4]  = mk(1'b0, 1'b1, 8'd4, 1'b1, 1'b1, 4'h3, 1'b0, 1'b1, 1'b0);
      vecs[5]  = mk(1'b0, 1'b1, 8'd4, 1'b0, 1'b1, 4'h4, 1'b1, 1'b1, 1'b0);
      vecs[6]  = mk(1'b0, 1'b1, 8'd4, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
      vecs[7]  = mk(1'b0, 1'b1, 8'd4, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
      // Rows 8-16: len 3, with tready low for two cycles on word 2. The
      // length input changes mid-packet and must be ignored.
      vecs[8]  = mk(1'b1, 1'b1, 8'd3, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
      vecs[9]  = mk(1'b0, 1'b1, 8'd9, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
      vecs[10] = mk(1'b0, 1'b1, 8'd9, 1'b1, 1'b1, 4'h1, 1'b0, 1'b1, 1'b0);
      vecs[11] = mk(1'b0, 1'b0, 8'd9, 1'b0, 1'b1, 4'h2, 1'b0, 1'b1, 1'b0);
      vecs[12] = mk(1'b0, 1'b0, 8'd9, 1'b0, 1'b1, 4'h2, 1'b0, 1'b1, 1'b0);
      vecs[13] = mk(1'b0, 1'b1, 8'd9, 1'b1, 1'b1, 4'h2, 1'b0, 1'b1, 1'b0);
      vecs[14] = mk(1'b0, 1'b1, 8'd9, 1'b0, 1'b1, 4'h3, 1'b1, 1'b1, 1'b0);
      vecs[15] = mk(1'b0, 1'b1, 8'd9, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
      vecs[16] = mk(1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);

      rst           = 1'b1;
      i_enable      = 1'b0;
      i_axis_tready = 1'b0;
      i_pkt_len     = 8'd0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("reset tvalid", int'(o_axis_tvalid), 0);
      checkOutput("reset tdata", int'(o_axis_tdata), 0);
      checkOutput("reset tlast", int'(o_axis_tlast), 0);
      checkOutput("reset done", int'(o_pkt_done), 0);
      checkOutput("reset busy", int'(o_busy), 0);
      checkOutput("reset stb", int'(o_fifo_r_stb), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      pushWord(4'h1); pushWord(4'h2); pushWord(4'h3); pushWord(4'h4);
      pushWord(4'h1); pushWord(4'h2); pushWord(4'h3);
      @(negedge clk);
      checkOutput("post-reset busy", int'(o_busy), 0);
      checkOutput("post-reset stb", int'(o_fifo_r_stb), 0);

      // Cycle-exact vector table
      for (int i = 0; i < 17; i++) begin
         applyStimulus(vecs[i].en, vecs[i].rdy, vecs[i].len);
         @(negedge clk);
         checkOutput($sformatf("vec%0d stb", i), int'(o_fifo_r_stb), int'(vecs[i].stb));
         checkOutput($sformatf("vec%0d tvalid", i), int'(o_axis_tvalid), int'(vecs[i].vld));
         if (vecs[i].vld) begin
            checkOutput($sformatf("vec%0d tdata", i), int'(o_axis_tdata), int'(vecs[i].data));
         end
         checkOutput($sformatf("vec%0d tlast", i), int'(o_axis_tlast), int'(vecs[i].last));
         checkOutput($sformatf("vec%0d busy", i), int'(o_busy), int'(vecs[i].busy));
         checkOutput($sformatf("vec%0d done", i), int'(o_pkt_done), int'(vecs[i].done));
      end
      checkOutput("table fifo drained", wrPtr - rdPtr, 0);

      // Zero length: enable held for 10 cycles with data waiting
      pushWord(4'h7);
      for (int c = 0; c < 10; c++) begin
         applyStimulus(1'b1, 1'b1, 8'd0);
         @(negedge clk);
         checkOutput("len0 stb", int'(o_fifo_r_stb), 0);
         checkOutput("len0 tvalid", int'(o_axis_tvalid), 0);
         checkOutput("len0 busy", int'(o_busy), 0);
      end

      // FIFO runs dry after word 1, and the rest arrives 5 cycles later
      base = rxData.size();
      doneBase = doneCnt;
      gap = 0;
      for (int c = 0; c < 20; c++) begin
         applyStimulus(c == 0, 1'b1, 8'd3);
         if (c == 6) begin
            pushWord(4'h8);
            pushWord(4'h9);
         end
         @(negedge clk);
         if (o_busy && !o_axis_tvalid && c > 2) begin
            gap++;
         end
      end
      checkOutput("stall gap cycles", gap, 4);
      checkOutput("stall done pulses", doneCnt - doneBase, 1);
      checkOutput("stall word count", rxData.size() - base, 3);
      if (rxData.size() - base == 3) begin
         checkOutput("stall word0", int'(rxData[base]), 7);
         checkOutput("stall word1", int'(rxData[base+1]), 8);
         checkOutput("stall word2", int'(rxData[base+2]), 9);
         checkOutput("stall last0", int'(rxLast[base]), 0);
         checkOutput("stall last1", int'(rxLast[base+1]), 0);
         checkOutput("stall last2", int'(rxLast[base+2]), 1);
      end

      // Reset after 2 of 4 words sent, then a 2-word packet
      pushWord(4'hA); pushWord(4'hB); pushWord(4'hC); pushWord(4'hD); pushWord(4'hE);
      base = rxData.size();
      ptrBase = rdPtr;
      applyStimulus(1'b1, 1'b1, 8'd4);
      n = 0;
      for (int c = 0; c < 20 && n < 2; c++) begin
         @(negedge clk);
         if (o_axis_tvalid && i_axis_tready) begin
            n++;
         end
         if (n < 2) begin
            @(posedge clk);
         end
      end
      checkOutput("abort two sent", n, 2);
      @(posedge clk);
      #1;
      rst = 1'b1;
      i_pkt_len = 8'd2;
      @(negedge clk);
      checkOutput("abort stb in reset", int'(o_fifo_r_stb), 0);
      checkOutput("abort busy in reset", int'(o_busy), 0);
      checkOutput("abort pops before reset", rdPtr - ptrBase, 3);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("abort tvalid after", int'(o_axis_tvalid), 0);
      checkOutput("abort busy after", int'(o_busy), 0);
      checkOutput("abort stb after", int'(o_fifo_r_stb), 0);
      doneBase = doneCnt;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         #1;
         if (doneCnt != doneBase) begin
            break;
         end
      end
      i_enable = 1'b0;
      checkOutput("abort restart done", doneCnt - doneBase, 1);
      checkOutput("abort word count", rxData.size() - base, 4);
      if (rxData.size() - base == 4) begin
         checkOutput("abort word0", int'(rxData[base]), 10);
         checkOutput("abort word1", int'(rxData[base+1]), 11);
         checkOutput("abort word2", int'(rxData[base+2]), 13);
         checkOutput("abort word3", int'(rxData[base+3]), 14);
         checkOutput("abort last2", int'(rxLast[base+2]), 0);
         checkOutput("abort last3", int'(rxLast[base+3]), 1);
      end

      // Back-to-back packets with enable held high
      for (int w = 1; w <= 6; w++) begin
         pushWord(4'(w));
      end
      base = rxData.size();
      nd = 0;
      for (int c = 0; c < 15; c++) begin
         applyStimulus(1'b1, 1'b1, 8'd2);
         @(negedge clk);
         if (o_pkt_done) begin
            if (nd < 3) begin
               doneAt[nd] = c;
            end
            nd++;
         end
         if (c == 5 || c == 10) begin
            checkOutput("b2b idle gap busy", int'(o_busy), 0);
         end
      end
      applyStimulus(1'b0, 1'b1, 8'd2);
      checkOutput("b2b done pulses", nd, 3);
      if (nd == 3) begin
         checkOutput("b2b done0 cycle", doneAt[0], 4);
         checkOutput("b2b done1 cycle", doneAt[1], 9);
         checkOutput("b2b done2 cycle", doneAt[2], 14);
      end
      checkOutput("b2b word count", rxData.size() - base, 6);
      if (rxData.size() - base == 6) begin
         for (int k = 0; k < 6; k++) begin
            checkOutput($sformatf("b2b word%0d", k), int'(rxData[base+k]), k + 1);
            checkOutput($sformatf("b2b last%0d", k), int'(rxLast[base+k]), k % 2);
         end
      end
      @(negedge clk);
      checkOutput("final busy", int'(o_busy), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
